// File: rtl/mesh_pkg.sv
// Shared constants and sizing helper for the mesh link buffer slice.
package mesh_pkg;

    localparam int FLIT_W_DEFAULT = 64;
    localparam int STATS_CNT_W    = 32;

    // Smallest width w >= 1 with 2**w >= n; sizes pointers and occupancy counters.
    function automatic int clog2_depth(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mesh_fifo_mem.sv
// DEPTH x WIDTH flit storage: one synchronous write port, one asynchronous read port.
module mesh_fifo_mem
    import mesh_pkg::*;
#(
    parameter int WIDTH = FLIT_W_DEFAULT,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage carries no reset; validity is tracked by the link's occupancy.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mesh_link_buf.sv
// Elastic valid/ready link between adjacent router ports. Optional MESH_LINK_STATS_EN adds flit_cnt.
// "do" is a SystemVerilog keyword, so the downstream flit port is named dout.
module mesh_link_buf
    import mesh_pkg::*;
#(
    parameter  int WIDTH = FLIT_W_DEFAULT,
    parameter  int DEPTH = 2,
    localparam int OCC_W = clog2_depth(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] di,
    input  logic             si,
    output logic             ri,
    output logic [WIDTH-1:0] dout,
    output logic             so,
    input  logic             ro,
    output logic [OCC_W-1:0] occ
`ifdef MESH_LINK_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0] flit_cnt
`endif
);

    localparam int               PTR_W    = clog2_depth(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             ri_r;
    logic             so_r;
    logic             push_s;
    logic             pop_s;
    logic             we_s;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [WIDTH-1:0] rdata_s;
    logic [WIDTH-1:0] dout_s;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    mesh_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (di),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Handshake qualification and next occupancy; ri/so come only from registered flags.
    always_comb begin
        push_s    = si & ri_r;
        pop_s     = so_r & ro;
        we_s      = push_s & ~reset;
        occ_nxt_s = occ_r + OCC_W'(push_s) - OCC_W'(pop_s);
    end

    // Pointer, occupancy and flag state; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
            ri_r     <= 1'b0;
            so_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            occ_r <= occ_nxt_s;
            ri_r  <= (occ_nxt_s != OCC_FULL);
            so_r  <= (occ_nxt_s != {OCC_W{1'b0}});
        end
    end

    // Head entry is masked to zero while empty so stale or unwritten storage never shows.
    always_comb begin
        if (so_r) begin
            dout_s = rdata_s;
        end else begin
            dout_s = {WIDTH{1'b0}};
        end
    end

    assign ri   = ri_r;
    assign so   = so_r;
    assign occ  = occ_r;
    assign dout = dout_s;

`ifdef MESH_LINK_STATS_EN
    logic [STATS_CNT_W-1:0] flit_cnt_r;

    // Downstream transfer counter, wraps modulo 2**32.
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_cnt_r <= {STATS_CNT_W{1'b0}};
        end else if (pop_s) begin
            flit_cnt_r <= flit_cnt_r + STATS_CNT_W'(1);
        end
    end

    assign flit_cnt = flit_cnt_r;
`endif

endmodule

// File: tb/tb_mesh_link_buf.sv
// Directed bench for mesh_link_buf at DEPTH=1,2,4,5; flit_cnt checks when MESH_LINK_STATS_EN is defined.
module tb_mesh_link_buf;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] di1, di2, di4, di5;
    logic [63:0] do1, do2, do4, do5;
    logic si1, si2, si4, si5, ro1, ro2, ro4, ro5;
    logic ri1, ri2, ri4, ri5, so1, so2, so4, so5;
    logic [0:0] occ1;
    logic [1:0] occ2;
    logic [2:0] occ4, occ5;
`ifdef MESH_LINK_STATS_EN
    logic [31:0] fc1, fc2, fc4, fc5;
`endif

    mesh_link_buf #(.WIDTH(64), .DEPTH(1)) d1 (.clk(clk), .reset(reset), .di(di1), .si(si1), .ri(ri1),
        .dout(do1), .so(so1), .ro(ro1), .occ(occ1)
`ifdef MESH_LINK_STATS_EN
        , .flit_cnt(fc1)
`endif
    );
    mesh_link_buf #(.WIDTH(64), .DEPTH(2)) d2 (.clk(clk), .reset(reset), .di(di2), .si(si2), .ri(ri2),
        .dout(do2), .so(so2), .ro(ro2), .occ(occ2)
`ifdef MESH_LINK_STATS_EN
        , .flit_cnt(fc2)
`endif
    );
    mesh_link_buf #(.WIDTH(64), .DEPTH(4)) d4 (.clk(clk), .reset(reset), .di(di4), .si(si4), .ri(ri4),
        .dout(do4), .so(so4), .ro(ro4), .occ(occ4)
`ifdef MESH_LINK_STATS_EN
        , .flit_cnt(fc4)
`endif
    );
    mesh_link_buf #(.WIDTH(64), .DEPTH(5)) d5 (.clk(clk), .reset(reset), .di(di5), .si(si5), .ri(ri5),
        .dout(do5), .so(so5), .ro(ro5), .occ(occ5)
`ifdef MESH_LINK_STATS_EN
        , .flit_cnt(fc5)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs are sampled 1 time unit after the rising edge, then new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        di1 = 64'd0; di2 = 64'd0; di4 = 64'd0; di5 = 64'd0;
        si1 = 1'b1; si2 = 1'b1; si4 = 1'b1; si5 = 1'b1;
        ro1 = 1'b0; ro2 = 1'b0; ro4 = 1'b0; ro5 = 1'b0;

        // 1: reset held three cycles with si=1
        repeat (3) tick();
        chk("rst_ri", {63'd0, ri4}, 64'd0);
        chk("rst_so", {63'd0, so4}, 64'd0);
        chk("rst_occ", {61'd0, occ4}, 64'd0);
        chk("rst_do", do4, 64'd0);
        chk("rst_ri_d1", {63'd0, ri1}, 64'd0);
        reset = 1'b0;
        si1 = 1'b0; si2 = 1'b0; si4 = 1'b0; si5 = 1'b0;
        tick();
        chk("rel_ri_d4", {63'd0, ri4}, 64'd1);
        chk("rel_ri_d1", {63'd0, ri1}, 64'd1);
        chk("rel_ri_d5", {63'd0, ri5}, 64'd1);
        chk("rel_so_d2", {63'd0, so2}, 64'd0);

        // 2: single flit, one cycle latency
        di4 = 64'hA5A5_0000_0000_0001; si4 = 1'b1; ro4 = 1'b1;
        tick();
        si4 = 1'b0;
        chk("lat_so", {63'd0, so4}, 64'd1);
        chk("lat_do", do4, 64'hA5A5_0000_0000_0001);
        chk("lat_occ", {61'd0, occ4}, 64'd1);
        tick();
        chk("lat_pop_so", {63'd0, so4}, 64'd0);
        chk("lat_pop_occ", {61'd0, occ4}, 64'd0);

        // 3: fill to full with ro=0, 5 and 6 refused, then drain
        ro4 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            di4 = 64'(i); si4 = 1'b1;
            tick();
        end
        si4 = 1'b0;
        chk("full_occ", {61'd0, occ4}, 64'd4);
        chk("full_ri", {63'd0, ri4}, 64'd0);
        chk("full_head", do4, 64'd1);
        ro4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_do", do4, 64'(k));
            tick();
            if (k == 1) chk("drain_ri_rise", {63'd0, ri4}, 64'd1);
        end
        chk("drain_so", {63'd0, so4}, 64'd0);
        chk("drain_occ", {61'd0, occ4}, 64'd0);
        ro4 = 1'b0;

        // 4: DEPTH=5 streaming, one flit per cycle across pointer wraps
        si5 = 1'b1; ro5 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            di5 = 64'(i);
            tick();
            chk("stream_do", do5, 64'(i));
            chk("stream_occ", {61'd0, occ5}, 64'd1);
        end
        si5 = 1'b0;
        tick();
        chk("stream_end_so", {63'd0, so5}, 64'd0);
        ro5 = 1'b0;

        // DEPTH=1 alternates full/empty
        di1 = 64'd1; si1 = 1'b1; ro1 = 1'b1;
        tick();
        chk("d1_do", do1, 64'd1);
        chk("d1_ri_full", {63'd0, ri1}, 64'd0);
        tick();
        chk("d1_so_empty", {63'd0, so1}, 64'd0);
        chk("d1_ri_back", {63'd0, ri1}, 64'd1);
        di1 = 64'd2;
        tick();
        chk("d1_do2", do1, 64'd2);
        chk("d1_occ", {63'd0, occ1}, 64'd1);
        si1 = 1'b0;
        tick();
        ro1 = 1'b0;

        // DEPTH=2 hold rule and refused push
        di2 = 64'hAA; si2 = 1'b1;
        tick();
        di2 = 64'hBB;
        tick();
        chk("d2_full_ri", {63'd0, ri2}, 64'd0);
        di2 = 64'hCC;
        tick();
        si2 = 1'b0;
        chk("d2_hold_do", do2, 64'hAA);
        chk("d2_hold_occ", {62'd0, occ2}, 64'd2);
        ro2 = 1'b1;
        tick();
        chk("d2_pop_do", do2, 64'hBB);
        chk("d2_pop_ri", {63'd0, ri2}, 64'd1);
        tick();
        chk("d2_empty", {63'd0, so2}, 64'd0);
        ro2 = 1'b0;

        // 5: simultaneous push+pop at occ=2, then reset mid-stream
        di4 = 64'h11; si4 = 1'b1;
        tick();
        di4 = 64'h22;
        tick();
        chk("pp_pre_occ", {61'd0, occ4}, 64'd2);
        di4 = 64'h7; ro4 = 1'b1;
        tick();
        si4 = 1'b0; ro4 = 1'b0;
        chk("pp_occ", {61'd0, occ4}, 64'd2);
        chk("pp_head", do4, 64'h22);
        reset = 1'b1;
        tick();
        chk("mid_rst_so", {63'd0, so4}, 64'd0);
        chk("mid_rst_occ", {61'd0, occ4}, 64'd0);
        reset = 1'b0;
        tick();
        chk("mid_rel_ri", {63'd0, ri4}, 64'd1);
        ro4 = 1'b1;
        tick();
        chk("mid_no_stale", {63'd0, so4}, 64'd0);
        di4 = 64'h99; si4 = 1'b1;
        tick();
        si4 = 1'b0;
        chk("mid_new_head", do4, 64'h99);
        tick();
        ro4 = 1'b0;

`ifdef MESH_LINK_STATS_EN
        // 6: transfer counter, three of ten flits stalled first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("cnt_zero", {32'd0, fc4}, 64'd0);
        for (int k = 1; k <= 10; k++) begin
            di4 = 64'(k); si4 = 1'b1; ro4 = 1'b0;
            tick();
            si4 = 1'b0;
            if (k <= 3) begin
                tick();
                chk("cnt_stall_do", do4, 64'(k));
            end
            ro4 = 1'b1;
            tick();
            ro4 = 1'b0;
        end
        chk("cnt_ten", {32'd0, fc4}, 64'd10);
        reset = 1'b1;
        tick();
        chk("cnt_rst", {32'd0, fc4}, 64'd0);
        reset = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
